// File: rtl/toggle_event_decoder.sv
// ============================================================================
// Module   : toggle_event_decoder
// Purpose  : Synchronizes a toggle-encoded event line, decodes each level
//            change into one event, and buffers events behind valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PEND_W      = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_in,
  input  logic              ev_ready,
  input  logic              clr,
  output logic              ev_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  ev_count,
  output logic              overflow,
  output logic              idle_timeout
);

  localparam int                c_warm_w    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_warm_w-1:0] c_warm_done = c_warm_w'(SYNC_STAGES + 1);
  localparam logic [c_warm_w-1:0] c_warm_one  = c_warm_w'(1);
  localparam logic [PEND_W-1:0] c_pend_one  = PEND_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
  localparam logic [15:0]       c_timeout   = 16'(TIMEOUT);
  localparam logic [15:0]       c_idle_one  = 16'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [c_warm_w-1:0]    r_warm;
  logic [PEND_W-1:0]      r_pending;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow;
  logic [15:0]            r_idle;
  logic                   r_idle_to;

  logic w_s;
  logic w_primed;
  logic w_edge;
  logic w_valid;
  logic w_pop;
  logic w_full;

  // The chain is cleared by reset, so edges stay masked until it has refilled
  // from the live line and prev holds a real sample; a line resting high
  // therefore never yields a spurious event after reset release.
  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_warm == c_warm_done);
  assign w_edge   = w_primed & (w_s ^ r_prev);
  assign w_valid  = (r_pending != '0);
  assign w_pop    = w_valid & ev_ready;
  assign w_full   = &r_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_warm     <= '0;
      r_pending  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_idle     <= '0;
      r_idle_to  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], t_in};
      r_prev <= w_s;
      if (!w_primed) begin
        r_warm <= r_warm + c_warm_one;
      end

      // Simultaneous push and pop cancel, which also avoids a drop when full.
      if (w_edge && !w_pop) begin
        if (!w_full) begin
          r_pending <= r_pending + c_pend_one;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_pop && !w_edge) begin
        r_pending <= r_pending - c_pend_one;
      end

      if (clr) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_idle     <= '0;
      end else begin
        if (w_edge) begin
          r_count <= r_count + c_cnt_one;
          r_idle  <= '0;
        end else if (r_idle != c_timeout) begin
          r_idle <= r_idle + c_idle_one;
        end
      end

      r_idle_to <= (r_idle == c_timeout);
    end
  end

  assign ev_valid     = w_valid;
  assign pending      = r_pending;
  assign ev_count     = r_count;
  assign overflow     = r_overflow;
  assign idle_timeout = r_idle_to;

endmodule

`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
// ============================================================================
// Module   : tb_toggle_event_decoder
// Purpose  : Directed self-checking bench for toggle_event_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_event_decoder;

  logic       clk;
  logic       reset;
  logic       t_in;
  logic       ev_ready;
  logic       clr;
  logic       ev_valid;
  logic [3:0] pending;
  logic [7:0] ev_count;
  logic       overflow;
  logic       idle_timeout;

  int total;
  int bad;

  toggle_event_decoder #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .PEND_W     (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .t_in        (t_in),
    .ev_ready    (ev_ready),
    .clr         (clr),
    .ev_valid    (ev_valid),
    .pending     (pending),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .idle_timeout(idle_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; t_in = 1'b0; ev_ready = 1'b0; clr = 1'b0;
    cyc(2);
    total++; if (pending !== 4'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
    total++; if (ev_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ev_count); end
    total++; if (ev_valid !== 1'b0 || overflow !== 1'b0 || idle_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000", ev_valid, overflow, idle_timeout);
    end
    reset = 1'b0;
    cyc(6);
  endtask

  task automatic test_basic();
    t_in = ~t_in;
    cyc(2);
    total++; if (pending !== 4'd0) begin bad++; $display("FAIL latency_early got=%0d want=0", pending); end
    cyc(1);
    total++; if (pending !== 4'd1) begin bad++; $display("FAIL latency_exact got=%0d want=1", pending); end
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      t_in = ~t_in;
      cyc(4);
    end
    total++; if (pending !== 4'd5) begin bad++; $display("FAIL basic_pending got=%0d want=5", pending); end
    total++; if (ev_count !== 8'd5) begin bad++; $display("FAIL basic_count got=%0d want=5", ev_count); end
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", ev_valid); end
  endtask

  task automatic test_drain();
    ev_ready = 1'b1;
    cyc(4);
    total++; if (pending !== 4'd1 || ev_valid !== 1'b1) begin
      bad++; $display("FAIL drain_4 got=%0d/%b want=1/1", pending, ev_valid);
    end
    cyc(1);
    total++; if (pending !== 4'd0 || ev_valid !== 1'b0) begin
      bad++; $display("FAIL drain_5 got=%0d/%b want=0/0", pending, ev_valid);
    end
    cyc(1);
    total++; if (pending !== 4'd0) begin bad++; $display("FAIL ready_empty got=%0d want=0", pending); end
    ev_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    t_in = ~t_in; cyc(4);
    t_in = ~t_in; cyc(4);
    total++; if (pending !== 4'd2) begin bad++; $display("FAIL b2b_setup got=%0d want=2", pending); end
    t_in = ~t_in;
    cyc(2);
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    total++; if (pending !== 4'd2) begin bad++; $display("FAIL push_pop got=%0d want=2", pending); end
    total++; if (ev_count !== 8'd8) begin bad++; $display("FAIL push_pop_count got=%0d want=8", ev_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      t_in = ~t_in; cyc(2);
    end
    cyc(3);
    total++; if (pending !== 4'd15 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_no_ovf got=%0d/%b want=15/0", pending, overflow);
    end
    for (int i = 0; i < 2; i++) begin
      t_in = ~t_in; cyc(2);
    end
    cyc(3);
    total++; if (pending !== 4'd15) begin bad++; $display("FAIL ovf_pending got=%0d want=15", pending); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    total++; if (ev_count !== 8'd17) begin bad++; $display("FAIL ovf_count got=%0d want=17", ev_count); end
    // Pop and push on the same edge while full.
    t_in = ~t_in;
    cyc(2);
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    total++; if (pending !== 4'd15 || overflow !== 1'b1 || ev_count !== 8'd18) begin
      bad++; $display("FAIL full_push_pop got=%0d/%b/%0d want=15/1/18", pending, overflow, ev_count);
    end
    clr = 1'b1; cyc(1); clr = 1'b0;
    total++; if (overflow !== 1'b0 || ev_count !== 8'd0 || pending !== 4'd15) begin
      bad++; $display("FAIL clr got=%b/%0d/%0d want=0/0/15", overflow, ev_count, pending);
    end
    ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
    // clr coincident with a detected edge: count cleared, edge still pushed.
    t_in = ~t_in;
    cyc(2);
    clr = 1'b1; cyc(1); clr = 1'b0;
    total++; if (ev_count !== 8'd0 || pending !== 4'd15) begin
      bad++; $display("FAIL clr_edge got=%0d/%0d want=0/15", ev_count, pending);
    end
  endtask

  task automatic test_priming();
    t_in = 1'b1;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(8);
    total++; if (pending !== 4'd0 || ev_count !== 8'd0 || ev_valid !== 1'b0) begin
      bad++; $display("FAIL prime_quiet got=%0d/%0d/%b want=0/0/0", pending, ev_count, ev_valid);
    end
    t_in = 1'b0;
    cyc(3);
    total++; if (ev_count !== 8'd1 || pending !== 4'd1) begin
      bad++; $display("FAIL prime_edge got=%0d/%0d want=1/1", ev_count, pending);
    end
  endtask

  task automatic test_idle();
    t_in = ~t_in;
    cyc(3);
    cyc(13);
    total++; if (idle_timeout !== 1'b0) begin bad++; $display("FAIL idle_early got=%b want=0", idle_timeout); end
    cyc(5);
    total++; if (idle_timeout !== 1'b1) begin bad++; $display("FAIL idle_set got=%b want=1", idle_timeout); end
    cyc(10);
    total++; if (idle_timeout !== 1'b1) begin bad++; $display("FAIL idle_hold got=%b want=1", idle_timeout); end
    t_in = ~t_in;
    cyc(5);
    total++; if (idle_timeout !== 1'b0) begin bad++; $display("FAIL idle_clear got=%b want=0", idle_timeout); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      t_in = ~t_in; cyc(1);
    end
    cyc(4);
    ev_ready = 1'b0;
    total++; if (ev_count !== 8'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", ev_count); end
    total++; if (pending !== 4'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL wrap_pending got=%0d/%b want=0/0", pending, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      t_in = ~t_in; cyc(2);
    end
    cyc(3);
    total++; if (pending !== 4'd3) begin bad++; $display("FAIL pre_reset got=%0d want=3", pending); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (pending !== 4'd0 || ev_valid !== 1'b0 || ev_count !== 8'd0 ||
                 overflow !== 1'b0 || idle_timeout !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%0d/%b/%0d/%b/%b want=0/0/0/0/0",
                      pending, ev_valid, ev_count, overflow, idle_timeout);
    end
    cyc(2);
    reset = 1'b0;
    cyc(6);
    t_in = ~t_in;
    cyc(3);
    total++; if (pending !== 4'd1 || ev_count !== 8'd1) begin
      bad++; $display("FAIL reprime got=%0d/%0d want=1/1", pending, ev_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_drain();
    test_back_to_back();
    test_overflow();
    test_priming();
    test_idle();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
